// File: rtl/jtag_types_pkg.sv
// Shared types and field offsets for the JTAG-to-AHB access register.
// Holds the request word layout and the status word bit indices.
package jtag_types_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } ahb_size_t;

    // Request word layout, LSB first
    localparam int RW_BIT   = 0;
    localparam int SIZE_LSB = 1;
    localparam int SIZE_W   = 2;
    localparam int AI_BIT   = 3;
    localparam int ADDR_LSB = 4;

    // Status word bit indices loaded on capture
    localparam int ST_RESP_VALID = 0;
    localparam int ST_OVERFLOW   = 1;
    localparam int ST_WFULL      = 2;
    localparam int ST_ERR        = 3;

    function automatic int size_bits(input ahb_size_t size);
        return 8 << size;
    endfunction

endpackage

// File: rtl/jtag_size_check.sv
// Combinational check that an AHB transfer size fits the configured data
// width, plus the byte step used for auto-incremented addresses.
module jtag_size_check
    import jtag_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  ahb_size_t         i_size,
    output logic              o_legal,
    output logic [ADDR_W-1:0] o_step
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_legal = 1'b0;
        o_step  = '0;
        o_legal = (size_bits(i_size) <= DATA_W);
        o_step  = ADDR_W'(1) << i_size;
    end

endmodule

// File: rtl/ahb_jtag_access_reg.sv
// JTAG data register carrying AHB requests into the request FIFO and
// returning responses on capture. Macro AHB_JTAG_AUTOINC_EN enables ai.
module ahb_jtag_access_reg
    import jtag_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SR_W   = DATA_W + ADDR_W + 4
) (
    input  logic              TCK,
    input  logic              nTRST,
    input  logic              TDI,
    output logic              TDO,
    input  logic              tlr_reset,
    input  logic              dr_shift,
    input  logic              dr_capture,
    input  logic              dr_update,
    input  logic              ahb_select,
    input  logic              wfull,
    output logic [SR_W-1:0]   parallel_out,
    output logic              winc,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rempty,
    output logic              rinc
);

    localparam int DATA_LSB = ADDR_LSB + ADDR_W;

    logic [SR_W-1:0]   r_sr;
    logic [SR_W-1:0]   r_parallel_out;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_winc;
    logic              r_rinc;
    logic              r_overflow;
    logic              r_err;

    logic              w_upd;
    logic              w_cap;
    logic              w_shf;
    logic              w_legal;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_eff_addr;
    logic [SR_W-1:0]   w_update_word;
    logic [SR_W-1:0]   w_status_word;

    // Update wins over capture, capture over shift
    assign w_upd = ahb_select & dr_update;
    assign w_cap = ahb_select & dr_capture & ~dr_update;
    assign w_shf = ahb_select & dr_shift & ~dr_capture & ~dr_update;

    jtag_size_check #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_size_check (
        .i_size  (ahb_size_t'(r_sr[SIZE_LSB +: SIZE_W])),
        .o_legal (w_legal),
        .o_step  (w_step)
    );

`ifdef AHB_JTAG_AUTOINC_EN
    always_comb begin
        w_eff_addr = r_sr[ADDR_LSB +: ADDR_W];
        if (r_sr[AI_BIT]) begin
            w_eff_addr = r_last_addr + w_step;
        end
    end
`else
    logic w_unused;
    assign w_unused   = ^{w_step, r_sr[AI_BIT]};
    assign w_eff_addr = r_sr[ADDR_LSB +: ADDR_W];
`endif

    always_comb begin
        w_update_word                      = r_sr;
        w_update_word[ADDR_LSB +: ADDR_W]  = w_eff_addr;
    end

    always_comb begin
        w_status_word                      = '0;
        w_status_word[ST_RESP_VALID]       = ~rempty;
        w_status_word[ST_OVERFLOW]         = r_overflow;
        w_status_word[ST_WFULL]            = wfull;
        w_status_word[ST_ERR]              = r_err;
        w_status_word[ADDR_LSB +: ADDR_W]  = r_last_addr;
        if (!rempty) begin
            w_status_word[DATA_LSB +: DATA_W] = rdata;
        end
    end

    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples the pre-edge values of its neighbours.
            r_sr           <= '0;
            r_parallel_out <= '0;
            r_last_addr    <= '0;
            r_winc         <= 1'b0;
            r_rinc         <= 1'b0;
            r_overflow     <= 1'b0;
            r_err          <= 1'b0;
        end else if (tlr_reset) begin
            r_sr           <= '0;
            r_parallel_out <= '0;
            r_last_addr    <= '0;
            r_winc         <= 1'b0;
            r_rinc         <= 1'b0;
            r_overflow     <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_winc <= 1'b0;
            r_rinc <= 1'b0;
            if (w_upd) begin
                r_parallel_out <= w_update_word;
                if (!w_legal) begin
                    r_err <= 1'b1;
                end else if (wfull) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_winc      <= 1'b1;
                    r_last_addr <= w_eff_addr;
                end
            end else if (w_cap) begin
                // Status bits are read-to-clear
                r_sr       <= w_status_word;
                r_rinc     <= ~rempty;
                r_overflow <= 1'b0;
                r_err      <= 1'b0;
            end else if (w_shf) begin
                r_sr <= {TDI, r_sr[SR_W-1:1]};
            end
        end
    end

    assign TDO          = r_sr[0];
    assign parallel_out = r_parallel_out;
    assign winc         = r_winc;
    assign rinc         = r_rinc;

endmodule

// File: tb/tb_ahb_jtag_access_reg.sv
// Directed bench for ahb_jtag_access_reg with default 32/32 widths.
// Expected words are built by hand from the request and status layouts.
module tb_ahb_jtag_access_reg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SR_W   = DATA_W + ADDR_W + 4;

    logic              TCK;
    logic              nTRST;
    logic              TDI;
    logic              TDO;
    logic              tlr_reset;
    logic              dr_shift;
    logic              dr_capture;
    logic              dr_update;
    logic              ahb_select;
    logic              wfull;
    logic [SR_W-1:0]   parallel_out;
    logic              winc;
    logic [DATA_W-1:0] rdata;
    logic              rempty;
    logic              rinc;

    int n_total;
    int n_passed;

    ahb_jtag_access_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .TCK          (TCK),
        .nTRST        (nTRST),
        .TDI          (TDI),
        .TDO          (TDO),
        .tlr_reset    (tlr_reset),
        .dr_shift     (dr_shift),
        .dr_capture   (dr_capture),
        .dr_update    (dr_update),
        .ahb_select   (ahb_select),
        .wfull        (wfull),
        .parallel_out (parallel_out),
        .winc         (winc),
        .rdata        (rdata),
        .rempty       (rempty),
        .rinc         (rinc)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [SR_W-1:0] act, input logic [SR_W-1:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [SR_W-1:0] req(input logic [31:0] data, input logic [31:0] addr,
                                            input logic ai, input logic [1:0] size, input logic rw);
        return {data, addr, ai, size, rw};
    endfunction

    function automatic logic [SR_W-1:0] stat(input logic [31:0] data, input logic [31:0] addr,
                                             input logic [3:0] bits);
        return {data, addr, bits};
    endfunction

    task automatic shift_io(input logic [SR_W-1:0] din, output logic [SR_W-1:0] dout);
        for (int i = 0; i < SR_W; i++) begin
            @(negedge TCK);
            dout[i]  = TDO;
            TDI      = din[i];
            dr_shift = 1'b1;
        end
        @(negedge TCK);
        dr_shift = 1'b0;
        TDI      = 1'b0;
    endtask

    task automatic do_update(input string tag, input logic full, input logic exp_winc);
        @(negedge TCK);
        dr_update = 1'b1;
        wfull     = full;
        @(negedge TCK);
        dr_update = 1'b0;
        check({tag, "_winc"}, winc, exp_winc);
        @(negedge TCK);
        wfull = 1'b0;
        check({tag, "_winc_end"}, winc, 1'b0);
    endtask

    task automatic do_capture(input string tag, input logic empty, input logic [31:0] data,
                              input logic full, output logic [SR_W-1:0] status);
        @(negedge TCK);
        dr_capture = 1'b1;
        rempty     = empty;
        rdata      = data;
        wfull      = full;
        @(negedge TCK);
        dr_capture = 1'b0;
        rempty     = 1'b1;
        rdata      = '0;
        wfull      = 1'b0;
        check({tag, "_rinc"}, rinc, !empty);
        @(negedge TCK);
        check({tag, "_rinc_end"}, rinc, 1'b0);
        shift_io('0, status);
    endtask

    logic [SR_W-1:0] junk;
    logic [SR_W-1:0] st;
    logic [31:0]     exp_addr [3];

    initial begin
        n_total    = 0;
        n_passed   = 0;
        nTRST      = 1'b0;
        TDI        = 1'b0;
        tlr_reset  = 1'b0;
        dr_shift   = 1'b0;
        dr_capture = 1'b0;
        dr_update  = 1'b0;
        ahb_select = 1'b1;
        wfull      = 1'b0;
        rdata      = '0;
        rempty     = 1'b1;
        repeat (2) @(negedge TCK);
        check("rst_tdo", TDO, 1'b0);
        check("rst_winc", winc, 1'b0);
        check("rst_rinc", rinc, 1'b0);
        check("rst_po", parallel_out, '0);
        nTRST = 1'b1;

        // Basic write
        shift_io(req(32'hDEADBEEF, 32'h1000, 1'b0, 2'd2, 1'b1), junk);
        do_update("basic", 1'b0, 1'b1);
        check("basic_po", parallel_out, {32'hDEADBEEF, 32'h0000_1000, 4'h5});
        do_capture("basic_cap", 1'b1, 32'h0, 1'b0, st);
        check("basic_status", st, stat(32'h0, 32'h1000, 4'b0000));

        // Overflow, then read-to-clear
        shift_io(req(32'hDEADBEEF, 32'h1000, 1'b0, 2'd2, 1'b1), junk);
        do_update("ovf", 1'b1, 1'b0);
        check("ovf_po", parallel_out, {32'hDEADBEEF, 32'h0000_1000, 4'h5});
        do_capture("ovf_cap1", 1'b1, 32'h0, 1'b1, st);
        check("ovf_status1", st, stat(32'h0, 32'h1000, 4'b0110));
        do_capture("ovf_cap2", 1'b1, 32'h0, 1'b0, st);
        check("ovf_status2", st, stat(32'h0, 32'h1000, 4'b0000));

        // Response capture
        do_capture("resp", 1'b0, 32'hCAFEF00D, 1'b0, st);
        check("resp_status", st, stat(32'hCAFEF00D, 32'h1000, 4'b0001));

        // Illegal size for 32-bit data
        shift_io(req(32'h0, 32'h2000, 1'b0, 2'd3, 1'b1), junk);
        do_update("illegal", 1'b0, 1'b0);
        do_capture("illegal_cap1", 1'b1, 32'h0, 1'b0, st);
        check("illegal_status1", st, stat(32'h0, 32'h1000, 4'b1000));
        do_capture("illegal_cap2", 1'b1, 32'h0, 1'b0, st);
        check("illegal_status2", st, stat(32'h0, 32'h1000, 4'b0000));

        // Auto-increment and back-to-back updates
`ifdef AHB_JTAG_AUTOINC_EN
        shift_io(req(32'h0, 32'hFFFF_FFFE, 1'b0, 2'd2, 1'b1), junk);
        do_update("ai_seed", 1'b0, 1'b1);
        exp_addr[0] = 32'h0000_0000;
        exp_addr[1] = 32'h0000_0002;
        exp_addr[2] = 32'h0000_0004;
`else
        exp_addr[0] = 32'h0000_3000;
        exp_addr[1] = 32'h0000_3000;
        exp_addr[2] = 32'h0000_3000;
`endif
        shift_io(req(32'h0, 32'h3000, 1'b1, 2'd1, 1'b1), junk);
        @(negedge TCK);
        dr_update = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge TCK);
            if (k == 2) dr_update = 1'b0;
            check("b2b_winc", winc, 1'b1);
            check("b2b_po", parallel_out, {32'h0, exp_addr[k], 4'hB});
        end
        @(negedge TCK);
        check("b2b_winc_end", winc, 1'b0);
        do_capture("ai_cap", 1'b1, 32'h0, 1'b0, st);
        check("ai_last_addr", st, stat(32'h0, exp_addr[2], 4'b0000));

        // Strobes without select do nothing
        ahb_select = 1'b0;
        @(negedge TCK);
        dr_update  = 1'b1;
        dr_capture = 1'b1;
        rempty     = 1'b0;
        @(negedge TCK);
        dr_update  = 1'b0;
        dr_capture = 1'b0;
        rempty     = 1'b1;
        check("nosel_winc", winc, 1'b0);
        check("nosel_rinc", rinc, 1'b0);
        check("nosel_po", parallel_out, {32'h0, exp_addr[2], 4'hB});
        ahb_select = 1'b1;

        // Update beats a simultaneous capture
        @(negedge TCK);
        dr_update  = 1'b1;
        dr_capture = 1'b1;
        rempty     = 1'b0;
        @(negedge TCK);
        dr_update  = 1'b0;
        dr_capture = 1'b0;
        rempty     = 1'b1;
        check("prio_winc", winc, 1'b1);
        check("prio_rinc", rinc, 1'b0);
        check("prio_po", parallel_out, '0);

        // Test-Logic-Reset clear
        shift_io(req(32'hDEADBEEF, 32'h1000, 1'b0, 2'd2, 1'b1), junk);
        do_update("tlr_pre", 1'b0, 1'b1);
        @(negedge TCK);
        tlr_reset = 1'b1;
        @(negedge TCK);
        tlr_reset = 1'b0;
        check("tlr_po", parallel_out, '0);

        // nTRST during the winc cycle
        shift_io(req(32'hDEADBEEF, 32'h1000, 1'b0, 2'd2, 1'b1), junk);
        @(negedge TCK);
        dr_update = 1'b1;
        @(negedge TCK);
        dr_update = 1'b0;
        check("rstw_winc_pre", winc, 1'b1);
        nTRST = 1'b0;
        #1;
        check("rstw_winc", winc, 1'b0);
        check("rstw_po", parallel_out, '0);
        @(negedge TCK);
        nTRST = 1'b1;

        // nTRST mid-shift
        for (int i = 0; i < SR_W + 2; i++) begin
            @(negedge TCK);
            TDI      = 1'b1;
            dr_shift = 1'b1;
        end
        @(negedge TCK);
        dr_shift = 1'b0;
        TDI      = 1'b0;
        check("rsts_tdo_pre", TDO, 1'b1);
        nTRST = 1'b0;
        #1;
        check("rsts_tdo", TDO, 1'b0);
        @(negedge TCK);
        nTRST = 1'b1;
        do_capture("rst_cap", 1'b1, 32'h0, 1'b0, st);
        check("rst_last_addr", st, '0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_jtag_access_reg.md
# ahb_jtag_access_reg

Parametrised JTAG data register that carries AHB access requests from the TAP into the TCK-domain write port of the request FIFO, and returns responses from the response FIFO on capture. It sits behind the TAP controller and instruction decoder, selected by `ahb_select`. It generalises the fixed 41-bit AHB register in four ways: configurable address and data widths, a response capture path, request-format checking, and sticky overflow/error status.

## Interface
Parameters:
- `ADDR_W`, 32: AHB address width.
- `DATA_W`, 32: AHB data width. Must be 8, 16, 32 or 64.
- `SR_W`, `DATA_W+ADDR_W+4`: shift-register width. Derived; do not override.

Ports:
- `TCK` in 1: JTAG clock. Only clock.
- `nTRST` in 1: asynchronous, active-low reset.
- `TDI` in 1: serial in.
- `TDO` out 1: serial out, equal to `sr[0]`.
- `tlr_reset` in 1: synchronous clear from Test-Logic-Reset.
- `dr_shift`, `dr_capture`, `dr_update` in 1 each: TAP DR strobes.
- `ahb_select` in 1: gates all three DR strobes.
- `wfull` in 1: request FIFO full.
- `parallel_out` out SR_W: latched request word.
- `winc` out 1: request FIFO push pulse.
- `rdata` in DATA_W: response FIFO head data.
- `rempty` in 1: response FIFO empty.
- `rinc` out 1: response FIFO pop pulse.

## Operation
Request word layout, LSB first:
- `[0]` rw: 1 = write.
- `[2:1]` size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `[3]` ai: auto-increment.
- `[4 +: ADDR_W]` addr.
- `[4+ADDR_W +: DATA_W]` wdata.

Behaviour for each strobe, always gated by `ahb_select`:
- **Shift:** `sr <= {TDI, sr[SR_W-1:1]}`.
- **Capture:** load status word:
  - `[0]` resp_valid = `!rempty`
  - `[1]` overflow
  - `[2]` wfull
  - `[3]` err
  - `[4 +: ADDR_W]` last_addr
  - data field = `rdata` if `!rempty`, else 0.
  - If `!rempty`, pulse `rinc`.
  - Capture clears the overflow and err sticky bits (read-to-clear).
- **Update:** `parallel_out <= sr`, with the address field replaced by the effective address (see Configuration). Then:
  - If the size encodes more than `DATA_W`, set `err`; no `winc`; `last_addr` unchanged.
  - Else if `wfull`, set `overflow`; no `winc`.
  - Else pulse `winc` and set `last_addr` to the effective address.
- **No select:** strobes without `ahb_select` have no effect; `TDO` still drives `sr[0]`.
- **Simultaneous strobes:** priority is update > capture > shift. Lower-priority strobes in the same cycle are ignored.
- **`tlr_reset`:** same clear as reset, applied at the next edge.

## Timing
- **Reset values:** `sr`, `parallel_out`, `last_addr`, overflow and err are 0. `winc`, `rinc` and `TDO` are 0.
- **`winc`:** registered. High for exactly the one TCK cycle after the update edge; `parallel_out` is stable from that same edge.
- **`wfull`:** sampled at the update edge only.
- **`rinc`:** registered. High for one cycle after the capture edge. `rdata` is sampled at the capture edge.
- **Shift latency:** a bit on `TDI` at edge k appears on `TDO` after SR_W shift edges.
- **Reset mid-pulse:** `nTRST` asserted while `winc` or `rinc` is high clears the pulse immediately, with no partial push or pop.
- **Back-to-back updates:** updates one cycle apart each produce their own `winc`. Overflow tracks each update independently.

## Configuration
Macro: `AHB_JTAG_AUTOINC_EN`.
- **Defined:**
  - An update with ai = 1 uses `last_addr + (1 << size)` as the effective address and ignores the shifted addr.
  - The sum wraps modulo 2^ADDR_W.
  - The first ai update after reset uses 0 + step.
- **Undefined:** the ai bit is ignored and the shifted addr is always used.

## Structure
Shared package `jtag_types_pkg` holds:
- the `ahb_size_t` enum;
- the field-offset localparams `RW_BIT`, `SIZE_LSB`, `AI_BIT`, `ADDR_LSB`;
- the status-bit indices.

Optional sub-module `jtag_size_check`: combinational legality check of size versus `DATA_W`, plus the step computation. Everything else lives in one module.

## Test plan
- **Basic write:** shift 68 bits (rw=1, size=2, ai=0, addr=0x1000, data=0xDEADBEEF), then update with `wfull`=0. `parallel_out` matches, `winc` is high for 1 cycle, `last_addr`=0x1000.
- **Overflow:** same update with `wfull`=1. No `winc`. The next capture shows status bit1=1; a second capture shows bit1=0.
- **Response capture:** `rempty`=0, `rdata`=0xCAFEF00D, then capture. `rinc` pulses once. Shifting out gives resp_valid=1 and data 0xCAFEF00D. With `rempty`=1: no `rinc` and data 0.
- **Illegal size:** `DATA_W`=32, size=3, update. err is set, no `winc`, `last_addr` unchanged.
- **Auto-increment (macro on):** `last_addr`=0xFFFFFFFE, ai=1, size=1. Effective address is 0x00000000 (wrap). Two further ai updates give 0x2 and 0x4.
- **Reset mid-operation:** assert `nTRST` during the `winc` cycle and mid-shift. All outputs go to 0 immediately. A later capture shows `last_addr`=0.
